// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package data_mem_responder_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned WCNT_W          = 4;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the CPU-side initiator and the responder.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              ReqValid;
  logic              ReqReady;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              RespValid;
  logic              RespReady;
  logic [DATA_W-1:0] ReadData;
  logic              RespError;

  modport master (
    output ReqValid, MemRead, MemWrite, Address, WriteData, RespReady,
    input  ReqReady, RespValid, ReadData, RespError
  );

  modport slave (
    input  ReqValid, MemRead, MemWrite, Address, WriteData, RespReady,
    output ReqReady, RespValid, ReadData, RespError
  );

endinterface

// File: rtl/data_mem_responder_data_ram.sv
// Single-port synchronous word RAM; read-before-write, contents not reset.
module data_ram
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: one outstanding request, fixed wait
// states, response held until the initiator takes it.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic Clock,
  input  logic Reset,
  data_mem_responder_if.slave bus
);

  state_e              r_state;
  state_e              w_next_state;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [WCNT_W-1:0]   w_wait_cnt_next;

  logic                r_rd;
  logic                r_wr;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_error;
  logic                r_rd_sel;

  logic                w_accept;
  logic                w_access;
  logic                w_acc_rd;
  logic                w_acc_wr;
  logic [DATA_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_acc_err;
  logic                w_we;
  logic [DATA_W-1:0]   w_ram_rdata;

  // Next-state, wait counter and access strobe; with zero wait states the
  // access happens on the accept edge itself, so it uses the live request.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_accept        = 1'b0;
    w_access        = 1'b0;
    w_acc_rd        = r_rd;
    w_acc_wr        = r_wr;
    w_acc_addr      = r_addr;
    w_acc_wdata     = r_wdata;

    case (r_state)
      ST_IDLE: begin
        w_acc_rd    = bus.MemRead;
        w_acc_wr    = bus.MemWrite;
        w_acc_addr  = bus.Address;
        w_acc_wdata = bus.WriteData;
        if (bus.ReqValid) begin
          w_accept        = 1'b1;
          w_wait_cnt_next = WCNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            w_access     = 1'b1;
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_wait_cnt_next = r_wait_cnt - WCNT_W'(1);
        if (r_wait_cnt == WCNT_W'(1)) begin
          w_access     = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.RespReady) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    w_acc_err = (w_acc_rd == w_acc_wr) || ((w_acc_addr >> ADDR_W) != '0);
    w_we      = w_access && w_acc_wr && !w_acc_err && !Reset;
  end

  // State register and handshake outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wait_cnt   <= w_wait_cnt_next;
      r_req_ready  <= (w_next_state == ST_IDLE);
      r_resp_valid <= (w_next_state == ST_RESP);
    end
  end

  // Request latch and response status
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_error <= 1'b0;
      r_rd_sel     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd    <= bus.MemRead;
        r_wr    <= bus.MemWrite;
        r_addr  <= bus.Address;
        r_wdata <= bus.WriteData;
      end
      if (w_access) begin
        r_resp_error <= w_acc_err;
        r_rd_sel     <= w_acc_rd && !w_acc_err;
      end else if ((r_state == ST_RESP) && bus.RespReady) begin
        r_resp_error <= 1'b0;
        r_rd_sel     <= 1'b0;
      end
    end
  end

  data_ram #(
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .Clock (Clock),
    .we    (w_we),
    .addr  (ADDR_W'(w_acc_addr)),
    .wdata (w_acc_wdata),
    .rdata (w_ram_rdata)
  );

  // RAM output register is only exposed for successful reads; its address is
  // frozen at the latched value while in RESP, so the data stays stable.
  assign bus.ReqReady  = r_req_ready;
  assign bus.RespValid = r_resp_valid;
  assign bus.RespError = r_resp_error;
  assign bus.ReadData  = r_rd_sel ? w_ram_rdata : '0;

endmodule
